// File: rtl/kbd_playback_ctrl.sv
// Playback command stage: turns decoded key flags into play/direction/restart
// state and paces sample-memory reads with one req/ack transaction per tick.
module kbd_playback_ctrl #(
    parameter int                ADDR_W     = 23,
    parameter logic [ADDR_W-1:0] START_ADDR = 23'h000000,
    parameter logic [ADDR_W-1:0] END_ADDR   = 23'h07FFFF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              key_d,
    input  logic              key_e,
    input  logic              key_b,
    input  logic              key_f,
    input  logic              key_r,
    input  logic              sample_tick,
    input  logic              rd_ack,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              playing,
    output logic              reverse,
    output logic              overrun
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    localparam int K_D = 0;
    localparam int K_E = 1;
    localparam int K_B = 2;
    localparam int K_F = 3;
    localparam int K_R = 4;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_state_next;
    logic [4:0]        r_key_prev;
    logic [4:0]        w_keys;
    logic [4:0]        w_edge;
    logic              r_playing;
    logic              w_playing_next;
    logic              r_reverse;
    logic              w_reverse_next;
    logic              r_overrun;
    logic              w_overrun_next;
    logic              r_restart_pend;
    logic              w_restart_pend_next;
    logic              w_restart_done;
    logic              r_rd_req;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W-1:0] w_addr_next;
    logic [ADDR_W-1:0] w_target;

    // Key edge detection and command decode.
    always_comb begin
        w_keys = {key_r, key_f, key_b, key_e, key_d};
        w_edge = w_keys & ~r_key_prev;

        if (w_edge[K_D]) begin
            w_playing_next = 1'b0;
        end else if (w_edge[K_E]) begin
            w_playing_next = 1'b1;
        end else begin
            w_playing_next = r_playing;
        end

        // Simultaneous B and F cancel each other.
        if (w_edge[K_B] && !w_edge[K_F]) begin
            w_reverse_next = 1'b1;
        end else if (w_edge[K_F] && !w_edge[K_B]) begin
            w_reverse_next = 1'b0;
        end else begin
            w_reverse_next = r_reverse;
        end

        w_target = w_reverse_next ? END_ADDR : START_ADDR;

        if (w_edge[K_R]) begin
            w_overrun_next = 1'b0;
        end else if (sample_tick && (r_state != ST_IDLE)) begin
            w_overrun_next = 1'b1;
        end else begin
            w_overrun_next = r_overrun;
        end
    end

    // Request sequencer next-state and address update.
    always_comb begin
        w_state_next   = r_state;
        w_addr_next    = r_rd_addr;
        w_restart_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_restart_pend) begin
                    w_addr_next    = w_target;
                    w_restart_done = 1'b1;
                end else if (sample_tick && r_playing) begin
                    w_state_next = ST_REQ;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (rd_ack) begin
                    w_state_next = ST_STEP;
                end else begin
                    w_state_next = ST_REQ;
                end
            end
            ST_STEP: begin
                w_state_next = ST_IDLE;
                if (r_restart_pend) begin
                    w_addr_next    = w_target;
                    w_restart_done = 1'b1;
                end else if (!r_reverse) begin
                    w_addr_next = (r_rd_addr == END_ADDR) ? START_ADDR : (r_rd_addr + ADDR_ONE);
                end else begin
                    w_addr_next = (r_rd_addr == START_ADDR) ? END_ADDR : (r_rd_addr - ADDR_ONE);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        // A restart requested in the same cycle an older one is consumed stays pending.
        w_restart_pend_next = w_edge[K_R] | (r_restart_pend & ~w_restart_done);
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Player state, key history and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_key_prev     <= 5'b00000;
            r_playing      <= 1'b0;
            r_reverse      <= 1'b0;
            r_overrun      <= 1'b0;
            r_restart_pend <= 1'b0;
            r_rd_req       <= 1'b0;
            r_rd_addr      <= START_ADDR;
        end else begin
            r_key_prev     <= w_keys;
            r_playing      <= w_playing_next;
            r_reverse      <= w_reverse_next;
            r_overrun      <= w_overrun_next;
            r_restart_pend <= w_restart_pend_next;
            r_rd_req       <= (w_state_next == ST_REQ);
            r_rd_addr      <= w_addr_next;
        end
    end

    assign rd_req  = r_rd_req;
    assign rd_addr = r_rd_addr;
    assign playing = r_playing;
    assign reverse = r_reverse;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_kbd_playback_ctrl.sv
// Self-checking bench for kbd_playback_ctrl: directed scenarios plus random
// key/tick/ack traffic, all checked against a transaction-level reference model.
module tb_kbd_playback_ctrl;

    localparam int unsigned START = 32'h0000_0000;
    localparam int unsigned ENDA  = 32'h0007_FFFF;
    localparam int unsigned SPAN  = ENDA - START + 32'd1;

    logic        clk;
    logic        reset_n;
    logic [4:0]  keys;  // {R, F, B, E, D}
    logic        sample_tick;
    logic        rd_ack;
    logic        rd_req;
    logic [22:0] rd_addr;
    logic        playing;
    logic        reverse;
    logic        overrun;

    int n_vec;
    int n_err;

    // Reference model state
    bit [4:0]    m_prev;
    bit          m_playing;
    bit          m_reverse;
    bit          m_overrun;
    bit          m_pend;
    bit          m_req;
    bit          m_step;
    int unsigned m_addr;

    kbd_playback_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .key_d       (keys[0]),
        .key_e       (keys[1]),
        .key_b       (keys[2]),
        .key_f       (keys[3]),
        .key_r       (keys[4]),
        .sample_tick (sample_tick),
        .rd_ack      (rd_ack),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .playing     (playing),
        .reverse     (reverse),
        .overrun     (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned addr_fwd(input int unsigned a);
        return START + ((a - START + 32'd1) % SPAN);
    endfunction

    function automatic int unsigned addr_back(input int unsigned a);
        return START + ((a - START + SPAN - 32'd1) % SPAN);
    endfunction

    task automatic model_reset();
        m_prev    = 5'b00000;
        m_playing = 1'b0;
        m_reverse = 1'b0;
        m_overrun = 1'b0;
        m_pend    = 1'b0;
        m_req     = 1'b0;
        m_step    = 1'b0;
        m_addr    = START;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit [4:0] e;
        bit       applied;
        bit       busy;
        bit       nrev;
        e       = keys & ~m_prev;
        m_prev  = keys;
        applied = 1'b0;
        busy    = m_req | m_step;
        nrev    = m_reverse;
        if (e[2] && !e[3]) nrev = 1'b1;
        else if (e[3] && !e[2]) nrev = 1'b0;

        if (m_step) begin
            if (m_pend) begin
                m_addr  = nrev ? ENDA : START;
                applied = 1'b1;
            end else begin
                m_addr = m_reverse ? addr_back(m_addr) : addr_fwd(m_addr);
            end
            m_step = 1'b0;
        end else if (m_req) begin
            if (rd_ack) begin
                m_req  = 1'b0;
                m_step = 1'b1;
            end
        end else if (m_pend) begin
            m_addr  = nrev ? ENDA : START;
            applied = 1'b1;
        end else if (sample_tick && m_playing) begin
            m_req = 1'b1;
        end

        if (e[4]) m_overrun = 1'b0;
        else if (sample_tick && busy) m_overrun = 1'b1;
        m_pend = (m_pend && !applied) || e[4];
        if (e[0]) m_playing = 1'b0;
        else if (e[1]) m_playing = 1'b1;
        m_reverse = nrev;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("rd_req",  {31'd0, rd_req},  {31'd0, m_req});
        chk("rd_addr", {9'd0, rd_addr},  m_addr);
        chk("playing", {31'd0, playing}, {31'd0, m_playing});
        chk("reverse", {31'd0, reverse}, {31'd0, m_reverse});
        chk("overrun", {31'd0, overrun}, {31'd0, m_overrun});
    endtask

    task automatic press(input logic [4:0] mask);
        keys = mask;
        cycle();
        keys = 5'b00000;
        cycle();
    endtask

    // One tick, acked dly cycles after the request appears, then the step cycle.
    task automatic serve(input int dly, input logic [31:0] exp_addr);
        sample_tick = 1'b1;
        cycle();
        sample_tick = 1'b0;
        chk("req_up", {31'd0, rd_req}, 32'd1);
        chk("req_addr", {9'd0, rd_addr}, exp_addr);
        repeat (dly) cycle();
        rd_ack = 1'b1;
        cycle();
        rd_ack = 1'b0;
        cycle();
    endtask

    initial begin
        logic saved_rev;
        n_vec       = 0;
        n_err       = 0;
        reset_n     = 1'b0;
        keys        = 5'b00000;
        sample_tick = 1'b0;
        rd_ack      = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req",     {31'd0, rd_req},  32'd0);
        chk("rst_addr",    {9'd0, rd_addr},  START);
        chk("rst_playing", {31'd0, playing}, 32'd0);
        chk("rst_reverse", {31'd0, reverse}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        reset_n = 1'b1;
        cycle();

        // Basic play: three ticks acked after two cycles
        press(5'b00010);
        for (int i = 0; i < 3; i++) serve(2, i);
        chk("t1_addr", {9'd0, rd_addr}, 32'h3);
        chk("t1_overrun", {31'd0, overrun}, 32'd0);

        // Wrap forward from END and backward from START
        press(5'b00100);
        press(5'b10000);
        chk("t2_restart_end", {9'd0, rd_addr}, ENDA);
        press(5'b01000);
        serve(1, ENDA);
        chk("t2_wrap_fwd", {9'd0, rd_addr}, START);
        press(5'b00100);
        serve(1, START);
        chk("t2_wrap_back", {9'd0, rd_addr}, ENDA);

        // Stop while a request is outstanding
        press(5'b01000);
        press(5'b10000);
        for (int i = 0; i < 16; i++) serve(0, i);
        sample_tick = 1'b1;
        cycle();
        sample_tick = 1'b0;
        keys = 5'b00001;
        cycle();
        keys = 5'b00000;
        chk("t3_req_held", {31'd0, rd_req}, 32'd1);
        chk("t3_stopped", {31'd0, playing}, 32'd0);
        cycle();
        rd_ack = 1'b1;
        cycle();
        rd_ack = 1'b0;
        cycle();
        chk("t3_addr", {9'd0, rd_addr}, 32'h11);
        for (int i = 0; i < 3; i++) begin
            sample_tick = 1'b1;
            cycle();
            sample_tick = 1'b0;
            chk("t3_no_req", {31'd0, rd_req}, 32'd0);
        end

        // Held E with D edge, then simultaneous edges
        for (int c = 0; c < 50; c++) begin
            keys = {3'b000, 1'b1, (c == 10)};
            cycle();
            if (c == 5) chk("t4_play_on", {31'd0, playing}, 32'd1);
        end
        chk("t4_no_replay", {31'd0, playing}, 32'd0);
        keys = 5'b00000;
        cycle();
        press(5'b00010);
        press(5'b00011);
        chk("t4_ed", {31'd0, playing}, 32'd0);
        saved_rev = reverse;
        press(5'b01100);
        chk("t4_bf", {31'd0, reverse}, {31'd0, saved_rev});

        // Overrun on tick while busy, cleared by R which also restarts
        press(5'b01010);
        sample_tick = 1'b1;
        cycle();
        sample_tick = 1'b0;
        cycle();
        cycle();
        sample_tick = 1'b1;
        cycle();
        sample_tick = 1'b0;
        chk("t5_overrun_set", {31'd0, overrun}, 32'd1);
        cycle();
        cycle();
        rd_ack = 1'b1;
        cycle();
        rd_ack = 1'b0;
        repeat (4) cycle();
        chk("t5_overrun_sticky", {31'd0, overrun}, 32'd1);
        keys = 5'b10000;
        cycle();
        chk("t5_overrun_clr", {31'd0, overrun}, 32'd0);
        keys = 5'b00000;
        cycle();
        chk("t5_restart", {9'd0, rd_addr}, START);

        // Asynchronous reset in the middle of a request
        for (int i = 0; i < 32'h42; i++) serve(0, i);
        sample_tick = 1'b1;
        cycle();
        sample_tick = 1'b0;
        chk("t6_req_at", {9'd0, rd_addr}, 32'h42);
        keys = 5'b00010;
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_req_drop", {31'd0, rd_req},  32'd0);
        chk("t6_addr_rst", {9'd0, rd_addr},  START);
        chk("t6_play_rst", {31'd0, playing}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cycle();
        chk("t6_play_after", {31'd0, playing}, 32'd1);

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 9) == 0) keys[k] = ~keys[k];
            end
            if ($urandom_range(0, 39) == 0) keys[4] = ~keys[4];
            sample_tick = ($urandom_range(0, 3) == 0);
            rd_ack      = ($urandom_range(0, 1) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
